keypad_scan_decoder: RTL

Parametrised keypad scanner and decoder for the matrix keypad front end. It drives one-hot column strobes and samples the row inputs through a synchroniser, then debounces the first key detected and emits a linear key code over a valid/ready handshake. It then waits for a debounced release before scanning resumes. It replaces the combinational column/row-to-code mapping and feeds the adder control logic.

---
 rtl/keypad_scan_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan_decoder.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling,
// debounced press detection, valid/ready key report, debounced release.
module keypad_scan_decoder #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4,
    localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_busy
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_REPORT,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [ROWS-1:0]   row_m_q, row_s_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  col_idx_q, col_idx_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic [ROWS-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;

    logic              tick;
    logic [ROW_W-1:0]  low_idx;
    logic [COL_W-1:0]  col_next;

    always_comb begin
        low_idx = '0;
        for (int unsigned i = ROWS; i > 0; i--) begin
            if (row_s_q[i-1]) low_idx = ROW_W'(i - 1);
        end
    end

    always_comb begin
        tick        = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d       = tick ? '0 : div_q + 1'b1;
        col_next    = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;

        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;

        unique case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (row_s_q == '0) begin
                        col_idx_d = col_next;
                    end else begin
                        row_idx_d = low_idx;
                        pat_d     = row_s_q;
                        cnt_d     = CNT_W'(1);
                        state_d   = (DEBOUNCE == 1) ? ST_REPORT : ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (row_s_q == pat_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) state_d = ST_REPORT;
                    end else begin
                        cnt_d     = '0;
                        col_idx_d = col_next;
                        state_d   = ST_SCAN;
                    end
                end
            end
            ST_REPORT: begin
                if (key_valid_q && key_ready) begin
                    key_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (!row_s_q[row_idx_q]) begin
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                            cnt_d     = '0;
                            col_idx_d = col_next;
                            state_d   = ST_SCAN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase

        // Code is captured on REPORT entry so it uses the row index being latched.
        if (state_d == ST_REPORT && state_q != ST_REPORT) begin
            key_code_d  = CODE_W'(int'(col_idx_q) * ROWS + int'(row_idx_d));
            key_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            row_m_q     <= '0;
            row_s_q     <= '0;
            div_q       <= '0;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            pat_q       <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_m_q     <= row_in;
            row_s_q     <= row_m_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        col_out            = '0;
        col_out[col_idx_q] = 1'b1;
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_busy  = (state_q != ST_SCAN);

endmodule
